// File: rtl/ula_sequencial_if.sv
// Register-bank side bundle of the sequential ALU: start/opcode/operands in,
// busy/done flags and the write port (enable, index, data) out.
interface ula_sequencial_if;
  logic        Inicia;
  logic [2:0]  Operacao;
  logic [31:0] OperandoA;
  logic [31:0] OperandoB;
  logic        Ocupado;
  logic        Pronto;
  logic        DivZero;
  logic        Escrita;
  logic [1:0]  IdReg;
  logic [31:0] Dado;

  modport master (
    output Inicia, Operacao, OperandoA, OperandoB,
    input  Ocupado, Pronto, DivZero, Escrita, IdReg, Dado
  );

  modport slave (
    input  Inicia, Operacao, OperandoA, OperandoB,
    output Ocupado, Pronto, DivZero, Escrita, IdReg, Dado
  );
endinterface

// File: rtl/ula_sequencial.sv
// Sequential ALU: single-cycle ADD/SUB/AND/OR/SLT, 32-step shift-add MUL and
// restoring DIV/MOD; every result is written to register ID_DESTINO.
module ula_sequencial #(
  parameter logic [1:0] ID_DESTINO = 2'b10
) (
  input  logic             Clock,
  input  logic             Reset,
  ula_sequencial_if.slave  bus
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] CALCULA = 2'd1;
  localparam logic [1:0] ESCREVE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_MOD = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [1:0]  state_reg;
  logic [2:0]  op_reg;
  logic [31:0] a_reg;     // MUL: shifted multiplicand; DIV/MOD: dividend turning into quotient
  logic [31:0] b_reg;     // MUL: shifted multiplier;   DIV/MOD: divisor
  logic [31:0] acc_reg;   // MUL: partial product;      DIV/MOD: partial remainder
  logic [5:0]  cnt_reg;
  logic        ocupado_reg;
  logic        escrita_reg;
  logic        divzero_reg;
  logic [31:0] dado_reg;

  logic        is_long;
  logic        is_divzero;
  logic [31:0] quick_res;
  logic [31:0] mul_acc_next;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        q_bit;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] final_res;

  // Results that are ready straight from the live inputs at the acceptance edge.
  always_comb begin
    quick_res  = 32'd0;
    is_divzero = 1'b0;
    case (bus.Operacao)
      OP_ADD: quick_res = bus.OperandoA + bus.OperandoB;
      OP_SUB: quick_res = bus.OperandoA - bus.OperandoB;
      OP_AND: quick_res = bus.OperandoA & bus.OperandoB;
      OP_OR:  quick_res = bus.OperandoA | bus.OperandoB;
      OP_DIV: begin
        quick_res  = 32'hFFFF_FFFF;
        is_divzero = (bus.OperandoB == 32'd0);
      end
      OP_MOD: begin
        quick_res  = bus.OperandoA;
        is_divzero = (bus.OperandoB == 32'd0);
      end
      OP_SLT: quick_res = ($signed(bus.OperandoA) < $signed(bus.OperandoB)) ? 32'd1 : 32'd0;
      default: quick_res = 32'd0;
    endcase
    is_long = (bus.Operacao == OP_MUL) ||
              (((bus.Operacao == OP_DIV) || (bus.Operacao == OP_MOD)) && !is_divzero);
  end

  // One iteration of either the multiplier or the restoring divider.
  always_comb begin
    mul_acc_next = acc_reg + (b_reg[0] ? a_reg : 32'd0);
    rem_shift    = {acc_reg, a_reg[31]};
    diff         = rem_shift - {1'b0, b_reg};
    q_bit        = ~diff[32];
    rem_next     = q_bit ? diff[31:0] : {acc_reg[30:0], a_reg[31]};
    quo_next     = {a_reg[30:0], q_bit};
    if (op_reg == OP_MUL)
      final_res = mul_acc_next;
    else if (op_reg == OP_DIV)
      final_res = quo_next;
    else
      final_res = rem_next;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg   <= OCIOSO;
      op_reg      <= OP_ADD;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      acc_reg     <= 32'd0;
      cnt_reg     <= 6'd0;
      ocupado_reg <= 1'b0;
      escrita_reg <= 1'b0;
      divzero_reg <= 1'b0;
      dado_reg    <= 32'd0;
    end else begin
      case (state_reg)
        OCIOSO: begin
          if (bus.Inicia) begin
            op_reg      <= bus.Operacao;
            a_reg       <= bus.OperandoA;
            b_reg       <= bus.OperandoB;
            acc_reg     <= 32'd0;
            cnt_reg     <= 6'd0;
            ocupado_reg <= 1'b1;
            if (is_long) begin
              state_reg <= CALCULA;
            end else begin
              state_reg   <= ESCREVE;
              escrita_reg <= 1'b1;
              divzero_reg <= is_divzero;
              dado_reg    <= quick_res;
            end
          end
        end
        CALCULA: begin
          if (op_reg == OP_MUL) begin
            acc_reg <= mul_acc_next;
            a_reg   <= a_reg << 1;
            b_reg   <= b_reg >> 1;
          end else begin
            acc_reg <= rem_next;
            a_reg   <= quo_next;
          end
          cnt_reg <= cnt_reg + 6'd1;
          // The last iteration's result goes straight to the write port.
          if (cnt_reg == 6'd31) begin
            state_reg   <= ESCREVE;
            escrita_reg <= 1'b1;
            dado_reg    <= final_res;
          end
        end
        ESCREVE: begin
          state_reg   <= OCIOSO;
          ocupado_reg <= 1'b0;
          escrita_reg <= 1'b0;
          divzero_reg <= 1'b0;
        end
        default: begin
          state_reg   <= OCIOSO;
          ocupado_reg <= 1'b0;
          escrita_reg <= 1'b0;
          divzero_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Ocupado = ocupado_reg;
  assign bus.Escrita = escrita_reg;
  assign bus.Pronto  = escrita_reg;
  assign bus.DivZero = divzero_reg;
  assign bus.Dado    = dado_reg;
  assign bus.IdReg   = ID_DESTINO;

endmodule

// File: tb/tb_ula_sequencial.sv
// Scoreboard bench for ula_sequencial: a driver pushes reference results,
// a negedge monitor pops and compares on every register-bank write.
module tb_ula_sequencial;

  typedef struct {
    logic [31:0] dado;
    logic        dz;
    int          cyc;
    string       name;
  } exp_t;

  logic Clock;
  logic Reset;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  logic rst_prev = 1'b0;
  logic [31:0] last_dado = 32'd0;
  exp_t exp_q[$];

  ula_sequencial_if bus();

  ula_sequencial #(.ID_DESTINO(2'b10)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  always @(posedge Clock) begin
    cyc      <= cyc + 1;
    rst_prev <= Reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  // Reference model: results straight from the arithmetic definitions.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic dz, output int lat);
    logic [63:0] prod;
    dz  = 1'b0;
    lat = 0;
    case (op)
      3'd0: res = a + b;
      3'd1: res = a - b;
      3'd2: res = a & b;
      3'd3: res = a | b;
      3'd4: begin prod = 64'(a) * 64'(b); res = prod[31:0]; lat = 32; end
      3'd5: if (b == 0) begin res = 32'hFFFF_FFFF; dz = 1'b1; end else begin res = a / b; lat = 32; end
      3'd6: if (b == 0) begin res = a;            dz = 1'b1; end else begin res = a % b; lat = 32; end
      default: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Called right after a negedge with the DUT idle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit noise);
    exp_t e;
    int lat;
    model(op, a, b, e.dado, e.dz, lat);
    e.name = name;
    e.cyc  = cyc + 1 + lat;
    exp_q.push_back(e);
    bus.Inicia = 1'b1; bus.Operacao = op; bus.OperandoA = a; bus.OperandoB = b;
    for (int i = 0; i <= lat; i++) begin
      @(negedge Clock);
      check({name, "_busy"}, bus.Ocupado, 1'b1);
      // Operands change and stray starts arrive while busy; neither may matter.
      bus.Inicia    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.Operacao  = 3'($urandom_range(0, 7));
      bus.OperandoA = $urandom;
      bus.OperandoB = $urandom;
    end
    @(negedge Clock);
    bus.Inicia = 1'b0;
    check({name, "_idle"}, bus.Ocupado, 1'b0);
  endtask

  // Monitor: one comparison set per cycle, decoupled from the driver.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (rst_prev) begin
        exp_q.delete();
        last_dado = 32'd0;
        check("reset_outs",
              {bus.Ocupado, bus.Escrita, bus.Pronto, bus.DivZero, bus.IdReg, bus.Dado},
              {1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 32'd0});
      end else if (bus.Escrita === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", bus.Escrita, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_dado"},   bus.Dado, e.dado);
          check({e.name, "_divz"},   bus.DivZero, e.dz);
          check({e.name, "_pronto"}, bus.Pronto, 1'b1);
          check({e.name, "_idreg"},  bus.IdReg, 2'b10);
          check({e.name, "_cycle"},  cyc, e.cyc);
          last_dado = e.dado;
          $display("write %-12s dado=%h divzero=%b cycle=%0d", e.name, bus.Dado, bus.DivZero, cyc);
        end
      end else begin
        check("idle_outs", {bus.Pronto, bus.DivZero, bus.Dado}, {1'b0, 1'b0, last_dado});
      end
    end
  end

  logic [2:0]  d_op [10] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2, 3'd3};
  logic [31:0] d_a  [10] = '{32'hFFFF_FFFF, 32'd12345, 32'd100, 32'd100, 32'd5, 32'd5,
                             32'hFFFF_FFFE, 32'd0, 32'hF0F0_1234, 32'h0F00_0001};
  logic [31:0] d_b  [10] = '{32'd1, 32'd678, 32'd7, 32'd7, 32'd0, 32'd0,
                             32'd1, 32'd1, 32'h0FF0_FF00, 32'h8000_0010};
  string       d_nm [10] = '{"add_wrap", "mul", "div", "mod", "div_zero", "mod_zero",
                             "slt_neg", "sub_wrap", "and", "or"};

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    Reset = 1'b1;
    bus.Inicia = 1'b0; bus.Operacao = 3'd0; bus.OperandoA = 32'd0; bus.OperandoB = 32'd0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);

    for (int i = 0; i < 10; i++) run_op(d_nm[i], d_op[i], d_a[i], d_b[i], bit'(i % 2));

    // MUL aborted by reset at N+20 after a stray ADD start at N+10.
    bus.Inicia = 1'b1; bus.Operacao = 3'd4; bus.OperandoA = 32'd12345; bus.OperandoB = 32'd678;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clock);
      check("abort_busy", bus.Ocupado, 1'b1);
      bus.Inicia   = (i == 10);
      bus.Operacao = 3'd0;
      if (i == 20) Reset = 1'b1;
    end
    @(negedge Clock);
    Reset = 1'b0;
    bus.Inicia = 1'b0;
    check("abort_idle", bus.Ocupado, 1'b0);
    @(negedge Clock);
    run_op("after_abort", 3'd0, 32'd7, 32'd8, 1'b0);

    // Reset and start in the same cycle: reset wins.
    Reset = 1'b1; bus.Inicia = 1'b1; bus.Operacao = 3'd0;
    @(negedge Clock);
    Reset = 1'b0; bus.Inicia = 1'b0;
    check("rst_dominates", bus.Ocupado, 1'b0);
    @(negedge Clock);
    check("rst_dominates_hold", bus.Ocupado, 1'b0);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, bit'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge Clock);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ula_sequencial.md
ULA_SEQUENCIAL -- requirements
Module: ula_sequencial

Interface
REQ-001 SHALL have parameter: ID_DESTINO, 2'b10, register-bank index receiving every result (accumulator).
REQ-002 SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of Clock.
REQ-003 Clock  input  1  system clock.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Inicia  input  1  start request; sampled only in OCIOSO.
REQ-006 Operacao  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110 MOD, 111 SLT.
REQ-007 OperandoA  input  32  first operand (register-bank read port 1).
REQ-008 OperandoB  input  32  second operand (register-bank read port 2).
REQ-009 Ocupado  output  1  high whenever state is not OCIOSO.
REQ-010 Pronto  output  1  one-cycle pulse coincident with Escrita.
REQ-011 DivZero  output  1  high with Pronto when DIV/MOD had OperandoB = 0.
REQ-012 Escrita  output  1  register-bank write enable.
REQ-013 IdReg  output  2  register-bank write index; always ID_DESTINO.
REQ-014 Dado  output  32  register-bank write data (result).

Function
REQ-015 SHALL implement FSM states OCIOSO, CALCULA, ESCREVE; all outputs registered.
REQ-016 In OCIOSO with Inicia=1 at edge N, SHALL latch OperandoA, OperandoB, Operacao; later changes on those inputs SHALL NOT affect the operation.
REQ-017 ADD/SUB/AND/OR/SLT SHALL go OCIOSO -> ESCREVE; Escrita/Pronto high during cycle N+1 (latency 1).
REQ-018 ADD/SUB SHALL wrap modulo 2^32, no overflow flag; SLT SHALL yield 32'd1 if A<B signed, else 32'd0.
REQ-019 MUL SHALL be unsigned shift-add, one bit per cycle, 32 cycles in CALCULA (N+1..N+32), ESCREVE at N+33; Dado = low 32 bits of product.
REQ-020 DIV/MOD SHALL be unsigned restoring division, 32 cycles in CALCULA, ESCREVE at N+33; DIV Dado = quotient, MOD Dado = remainder.
REQ-021 DIV/MOD with latched B=0 SHALL skip CALCULA, ESCREVE at N+1, DivZero=1; DIV Dado=32'hFFFFFFFF, MOD Dado=latched A.
REQ-022 ESCREVE SHALL last exactly one cycle, then OCIOSO unconditionally.
REQ-023 Inicia while in CALCULA or ESCREVE SHALL be ignored (not queued); earliest new acceptance is the cycle after ESCREVE.
REQ-024 Outside ESCREVE: Escrita=0, Pronto=0, DivZero=0; Dado SHALL hold last written result.
REQ-025 Iteration counter SHALL be 6 bits, loaded 0 on entry to CALCULA, exit when it reaches 31 (32 iterations).

Reset
REQ-026 Reset=1 at an edge SHALL force OCIOSO, Ocupado=0, Pronto=0, DivZero=0, Escrita=0, Dado=32'd0, IdReg=ID_DESTINO, counter=0.
REQ-027 Reset during CALCULA or ESCREVE SHALL abort; no Escrita pulse for the aborted operation.
REQ-028 Reset SHALL dominate Inicia in the same cycle.

Verification
REQ-029 ADD A=32'hFFFFFFFF, B=32'd1 -> one cycle later Escrita=1, IdReg=2'b10, Dado=32'd0, Pronto=1 one cycle.
REQ-030 MUL A=32'd12345, B=32'd678 -> Ocupado high 33 cycles, Dado=32'd8369910 at cycle N+33, single Pronto pulse.
REQ-031 DIV A=32'd100, B=32'd7 -> Dado=32'd14 at N+33; MOD same operands -> Dado=32'd2.
REQ-032 DIV A=32'd5, B=0 -> at N+1 Dado=32'hFFFFFFFF, DivZero=1, Pronto=1; MOD A=5, B=0 -> Dado=32'd5.
REQ-033 Start MUL, pulse Inicia with ADD at cycle N+10, assert Reset at N+20 -> no Escrita ever, Ocupado=0 at N+21, next Inicia accepted normally.
REQ-034 SLT A=32'hFFFFFFFE (-2), B=32'd1 -> Dado=32'd1; SUB A=0, B=1 -> Dado=32'hFFFFFFFF.
